loop_over_all_nibbles: RTL and testbench
========================================

Name: loop_over_all_nibbles

Overview:
- Nibble-serial 32-bit adder/subtractor used as the core ALU.
- Processes one 4-bit nibble per clock, starting at nibble 0 and moving up.
- The control FSM stalls while busy is high and samples result on the first edge where busy is low.
- Serves PC increment, ADDI/AUIPC/JAL address arithmetic, and load/store address calculation.

Parameters:
- NIBBLES, 8, number of 4-bit nibbles in a word (fixed to 8 for 32-bit operation).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- loop_perm_to_count  in  1  request/permission to compute; must stay high until busy is low.
- ctrl  in  2  bit0 carry_in, bit1 invert_word2 (ADD=00, SUB=11).
- loop_nibbles_number  in  3  index of the last significant nibble of word2 (0..7).
- word2_is_negative  in  1  nibbles of word2 above loop_nibbles_number read as 0xF (else 0x0).
- word1  in  32  first operand.
- word2  in  32  second operand; only nibbles 0..loop_nibbles_number are used.
- preinit_result  in  32  seed value for the result register when an operation starts.
- result  out  32  combinational: partial register with the current nibble's sum merged in.
- busy  out  1  combinational: high while further nibbles remain after the current one.

Behaviour:
- Registers:
  - idx (3 bit): current nibble index.
  - carry (1 bit): carry into the current nibble.
  - partial (32 bit): partial result.
  - active (1 bit): an operation is in progress.
- Reset: idx=0, carry=0, active=0, partial=0. Consequently busy=0 and result=0 while loop_perm_to_count is low.
- Operand nibble for index i:
  - b_i = word2[4i+3:4i] when i <= loop_nibbles_number.
  - Otherwise b_i = 4'hF if word2_is_negative, else 4'h0.
  - If invert_word2 is set, b_i is bitwise inverted.
- Carry into the current nibble: ctrl.carry_in on the first cycle of an operation, otherwise the carry register.
- Per-cycle sum: {cout, s} = word1 nibble i + b_i + carry-in.
- First cycle (loop_perm_to_count high, active=0):
  - idx is treated as 0.
  - Base value for the merge is preinit_result (not partial).
- result is the base value with nibble idx replaced by s.
- Termination condition "done" is true when either:
  - idx == 7, or
  - early exit applies (see Optional Feature).
- busy = loop_perm_to_count && !done.
- Clock edge with busy high: partial <= result, carry <= cout, idx <= idx+1, active <= 1.
- Clock edge with busy low, or with loop_perm_to_count low: idx=0, carry=0, active=0. The final value is consumed by the control FSM at that same edge.
- Final result equals (word1 + ext(word2) + carry_in) mod 2^32, where ext() is the sign/zero extension above the significant nibbles. The value is independent of the early-exit setting.
- Latency without early exit: always 8 cycles.
- Dropping loop_perm_to_count mid-operation aborts the operation. Next request restarts from nibble 0.
- Reset mid-operation aborts; takes priority over everything else.
- Inputs must be held stable for the whole operation.
- Carry out of nibble 7 is discarded (wrap-around).
- loop_nibbles_number = 7 with word2_is_negative high: extension has no effect.

Optional Feature:
- Macro: LOOP_EARLY_EXIT_EN.
- Defined: done is also true when all of the following hold:
  - idx >= loop_nibbles_number,
  - cout == 0,
  - word2_is_negative == 0 and invert_word2 == 0,
  - preinit_result[31:4(idx+1)] == word1[31:4(idx+1)].
- Effect: higher nibbles are taken unchanged from the seed, so PC increments with no carry finish in 1 cycle.
- Undefined: the loop always runs to nibble 7; latency is a fixed 8 cycles.

Test Plan:
- PC increment, early exit on: word1=preinit=0x000000FF, word2=4, N=0, ADD → result 0x00000103, busy high for 2 cycles, done on cycle 3.
- ADDI: word1=0, word2=0x07B, N=2, not negative, preinit=0 → 0x0000007B. Then word1=0x7B, word2=2 → 0x0000007D.
- Negative immediate: word1=0, word2=0x800, N=2, negative → 0xFFFFF800, 8 cycles.
- SUB: word1=10, word2=3, ctrl=11, N=7 → 7. Also word1=0, word2=1 → 0xFFFFFFFF.
- Wrap-around: word1=0xFFFFFFFF, word2=1, N=0 → 0x00000000, 8 cycles.
- Abort: rst asserted on cycle 3 of an operation → busy=0 next cycle. A new request with word1=5, word2=6, N=0 gives 11.

Source files
------------

// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial 32-bit adder/subtractor: one 4-bit nibble per clock, low nibble first.
// Optional early termination when upper nibbles match the seed: define LOOP_EARLY_EXIT_EN.
module loop_over_all_nibbles #(
  parameter int NIBBLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        loop_perm_to_count,
  input  logic [1:0]  ctrl,
  input  logic [2:0]  loop_nibbles_number,
  input  logic        word2_is_negative,
  input  logic [31:0] word1,
  input  logic [31:0] word2,
  input  logic [31:0] preinit_result,
  output logic [31:0] result,
  output logic        busy
);

  logic [2:0]  idx;
  logic        carry;
  logic [31:0] partial;
  logic        active;

  logic        first;
  logic [2:0]  cur_idx;
  logic [4:0]  lsb;
  logic        cin;
  logic [3:0]  a_nib;
  logic [3:0]  b_raw;
  logic [3:0]  b_nib;
  logic [3:0]  s;
  logic        cout;
  logic [31:0] base;
  logic [31:0] merged;
  logic        early;
  logic        done;
`ifdef LOOP_EARLY_EXIT_EN
  logic [5:0]  shamt;
  logic [31:0] upper_mask;
`endif

  always_comb begin
    first   = loop_perm_to_count && !active;
    cur_idx = first ? 3'd0 : idx;
    lsb     = {cur_idx, 2'b00};
    cin     = first ? ctrl[0] : carry;
    a_nib   = word1[lsb +: 4];
    // Nibbles above the significant range come from the sign/zero extension.
    if (cur_idx <= loop_nibbles_number) begin
      b_raw = word2[lsb +: 4];
    end else begin
      b_raw = word2_is_negative ? 4'hF : 4'h0;
    end
    b_nib       = ctrl[1] ? ~b_raw : b_raw;
    {cout, s}   = {1'b0, a_nib} + {1'b0, b_nib} + {4'd0, cin};
    base        = first ? preinit_result : partial;
    merged      = base;
    merged[lsb +: 4] = s;
  end

`ifdef LOOP_EARLY_EXIT_EN
  // Finished once nothing more can change: no carry, no extension, seed already equals word1 above.
  always_comb begin
    shamt      = {1'b0, cur_idx, 2'b00} + 6'd4;
    upper_mask = 32'hFFFF_FFFF << shamt;
    early      = (cur_idx >= loop_nibbles_number) && !cout &&
                 !word2_is_negative && !ctrl[1] &&
                 ((preinit_result & upper_mask) == (word1 & upper_mask));
  end
`else
  assign early = 1'b0;
`endif

  assign done = (cur_idx == 3'(NIBBLES - 1)) || early;
  assign busy = loop_perm_to_count && !done;
  // With no request pending, expose the stored partial so an idle unit reads as zero after reset.
  assign result = loop_perm_to_count ? merged : partial;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 3'd0;
      carry   <= 1'b0;
      partial <= 32'd0;
      active  <= 1'b0;
    end else if (busy) begin
      partial <= merged;
      carry   <= cout;
      idx     <= cur_idx + 3'd1;
      active  <= 1'b1;
    end else begin
      idx    <= 3'd0;
      carry  <= 1'b0;
      active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// Scoreboard bench for loop_over_all_nibbles: driver queues expected result/latency, monitor checks.
module tb_loop_over_all_nibbles;

  logic        clk = 1'b0;
  logic        rst;
  logic        loop_perm_to_count;
  logic [1:0]  ctrl;
  logic [2:0]  loop_nibbles_number;
  logic        word2_is_negative;
  logic [31:0] word1;
  logic [31:0] word2;
  logic [31:0] preinit_result;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];
  int          exp_id_q[$];

  loop_over_all_nibbles #(.NIBBLES(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .loop_perm_to_count  (loop_perm_to_count),
    .ctrl                (ctrl),
    .loop_nibbles_number (loop_nibbles_number),
    .word2_is_negative   (word2_is_negative),
    .word1               (word1),
    .word2               (word2),
    .preinit_result      (preinit_result),
    .result              (result),
    .busy                (busy)
  );

  always #5 clk = ~clk;

`ifdef LOOP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  // Monitor: counts request cycles and checks on the cycle busy falls.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !loop_perm_to_count) begin
        cnt = 0;
      end else begin
        cnt++;
        if (!busy) begin
          if (exp_res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h, no transaction expected", result);
          end else begin
            logic [31:0] er;
            int el;
            int id;
            er = exp_res_q.pop_front();
            el = exp_lat_q.pop_front();
            id = exp_id_q.pop_front();
            checks++;
            if (result !== er) begin
              errors++;
              $display("FAIL result_op%0d: got %h, expected %h", id, result, er);
            end
            checks++;
            if (cnt != el) begin
              errors++;
              $display("FAIL latency_op%0d: got %0d cycles, expected %0d", id, cnt, el);
            end
          end
        end
      end
    end
  end

  task automatic run_op(input int id, input logic [1:0] c, input logic [2:0] n,
                        input logic neg, input logic [31:0] w1, input logic [31:0] w2,
                        input logic [31:0] pre, input logic [31:0] er,
                        input int lat_ee, input int lat_def);
    bit finished = 0;
    @(posedge clk);
    #1;
    ctrl = c;
    loop_nibbles_number = n;
    word2_is_negative = neg;
    word1 = w1;
    word2 = w2;
    preinit_result = pre;
    exp_res_q.push_back(er);
    exp_lat_q.push_back(EE ? lat_ee : lat_def);
    exp_id_q.push_back(id);
    loop_perm_to_count = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL timeout_op%0d: busy still %b after 20 cycles, expected 0", id, busy);
    end
    @(posedge clk);
    #1;
    loop_perm_to_count = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    loop_perm_to_count = 1'b0;
    ctrl = 2'b00;
    loop_nibbles_number = 3'd0;
    word2_is_negative = 1'b0;
    word1 = 32'h1234_5678;
    word2 = 32'h9ABC_DEF0;
    preinit_result = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h, expected 00000000", result); end

    // PC increment: 0xFF + 4
    run_op(1, 2'b00, 3'd0, 1'b0, 32'h0000_00FF, 32'h4, 32'h0000_00FF, 32'h0000_0103, 3, 8);
    // ADDI pair
    run_op(2, 2'b00, 3'd2, 1'b0, 32'h0, 32'h07B, 32'h0, 32'h0000_007B, 3, 8);
    run_op(3, 2'b00, 3'd2, 1'b0, 32'h7B, 32'h2, 32'h0, 32'h0000_007D, 3, 8);
    // Negative immediate, sign-extended above nibble 2
    run_op(4, 2'b00, 3'd2, 1'b1, 32'h0, 32'h800, 32'h0, 32'hFFFF_F800, 8, 8);
    // SUB
    run_op(5, 2'b11, 3'd7, 1'b0, 32'd10, 32'd3, 32'h0, 32'd7, 8, 8);
    run_op(6, 2'b11, 3'd7, 1'b0, 32'd0, 32'd1, 32'h0, 32'hFFFF_FFFF, 8, 8);
    // Wrap-around discards carry out of nibble 7
    run_op(7, 2'b00, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 8, 8);
    // Full-width word2 with negative flag: extension has no effect
    run_op(8, 2'b00, 3'd7, 1'b1, 32'h1, 32'h8000_0000, 32'h0, 32'h8000_0001, 8, 8);

    // Abort with reset on cycle 3 of an operation
    @(posedge clk);
    #1;
    ctrl = 2'b00; loop_nibbles_number = 3'd7; word2_is_negative = 1'b1;
    word1 = 32'h1111_1111; word2 = 32'h2222_2222; preinit_result = 32'hDEAD_BEEF;
    loop_perm_to_count = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    loop_perm_to_count = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL abort_result: got %h, expected 00000000", result); end

    run_op(9, 2'b00, 3'd0, 1'b0, 32'd5, 32'd6, 32'h0, 32'd11, 1, 8);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_res_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_res_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
